// File: rtl/alu_8.sv
// rtl/alu_8.sv - registered 8-operation ALU with carry, overflow and sign flags
module alu_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ov,
  output logic             sign,
  output logic             valid
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             lt;
  logic [WIDTH-1:0] z_next;
  logic             cout_next;
  logic             ov_next;

  // ADD and SUB share one adder; SUB is a + ~b + 1 so cout=1 means no borrow.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign lt     = ($signed(a) < $signed(b));

  always_comb begin
    z_next    = '0;
    cout_next = 1'b0;
    ov_next   = 1'b0;
    case (op)
      OP_ADD: begin
        z_next    = sum[WIDTH-1:0];
        cout_next = sum[WIDTH];
        ov_next   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        z_next    = sum[WIDTH-1:0];
        cout_next = sum[WIDTH];
        ov_next   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: z_next = a & b;
      OP_OR:  z_next = a | b;
      OP_XOR: z_next = a ^ b;
      OP_SHL: begin
        z_next    = {a[WIDTH-2:0], 1'b0};
        cout_next = a[WIDTH-1];
      end
      OP_SHR: begin
        z_next    = {1'b0, a[WIDTH-1:1]};
        cout_next = a[0];
      end
      OP_SLT: z_next = {{(WIDTH-1){1'b0}}, lt};
      default: z_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z     <= '0;
      cout  <= 1'b0;
      ov    <= 1'b0;
      sign  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        z    <= z_next;
        cout <= cout_next;
        ov   <= ov_next;
        sign <= z_next[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_8.sv
// tb/tb_alu_8.sv - table-driven self-checking bench for alu_8
module tb_alu_8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic [7:0] z;
  logic       cout;
  logic       ov;
  logic       sign;
  logic       valid;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] z;
    logic       cout;
    logic       ov;
    logic       sign;
  } vec_t;

  vec_t vecs[21];

  alu_8 dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .op(op),
    .z(z), .cout(cout), .ov(ov), .sign(sign), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [7:0] ez, input logic ec,
                           input logic eo, input logic es, input logic ev);
    check({name, ".z"}, idx, z, ez);
    check({name, ".cout"}, idx, {7'd0, cout}, {7'd0, ec});
    check({name, ".ov"}, idx, {7'd0, ov}, {7'd0, eo});
    check({name, ".sign"}, idx, {7'd0, sign}, {7'd0, es});
    check({name, ".valid"}, idx, {7'd0, valid}, {7'd0, ev});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    //            a       b       op      z       c     o     s
    vecs[0]  = '{8'd100, 8'd124, 3'b000, 8'd224, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{8'd100, 8'd124, 3'b001, 8'd232, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'd100, 8'd124, 3'b010, 8'd100, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'd100, 8'd124, 3'b011, 8'd124, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'd100, 8'd124, 3'b100, 8'd24,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'd100, 8'd124, 3'b101, 8'd200, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'd100, 8'd124, 3'b110, 8'd50,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'd100, 8'd124, 3'b111, 8'd1,   1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'd110, 8'd200, 3'b000, 8'd54,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'd110, 8'd200, 3'b001, 8'd166, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'd110, 8'd200, 3'b010, 8'd72,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'd110, 8'd200, 3'b011, 8'd238, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'd110, 8'd200, 3'b100, 8'd166, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'd110, 8'd200, 3'b101, 8'd220, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'd110, 8'd200, 3'b110, 8'd55,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{8'd110, 8'd200, 3'b111, 8'd0,   1'b0, 1'b0, 1'b0};
    vecs[16] = '{8'd255, 8'd1,   3'b000, 8'd0,   1'b1, 1'b0, 1'b0};
    vecs[17] = '{8'd127, 8'd1,   3'b000, 8'd128, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{8'd0,   8'd1,   3'b001, 8'd255, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{8'h81,  8'd0,   3'b101, 8'h02,  1'b1, 1'b0, 1'b0};
    vecs[20] = '{8'h01,  8'd0,   3'b110, 8'd0,   1'b1, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; a = 8'd0; b = 8'd0; op = 3'b000;
    #3;
    check_all("reset", 0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("idle", 0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      en = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      @(posedge clk);
      #1;
      check_all("vec", i, vecs[i].z, vecs[i].cout, vecs[i].ov, vecs[i].sign, 1'b1);
    end

    @(negedge clk);
    a = 8'd100; b = 8'd124; op = 3'b000;
    @(posedge clk);
    #1;
    check_all("hold_pre", 0, 8'd224, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; a = 8'(8'd7 + i); b = 8'(8'd250 - i); op = 3'(i + 1);
      @(posedge clk);
      #1;
      check_all("hold", i, 8'd224, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    en = 1'b1; a = 8'd1; b = 8'd2; op = 3'b000;
    @(posedge clk);
    #1;
    check_all("resume", 0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = 8'd200; b = 8'(8'd100 + i); op = 3'b000;
      @(posedge clk);
      #1;
    end
    check_all("stream", 0, 8'd45, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_all("midrst", 0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("midrst_hold", 0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst", 0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b1; a = 8'd5; b = 8'd6; op = 3'b000;
    @(posedge clk);
    #1;
    check_all("first_after", 0, 8'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drop", 0, {7'd0, valid}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_8.md
Name: alu_8

Overview:
- 8-bit, 8-operation arithmetic/logic unit with carry-out, signed-overflow and sign flags.
- Operands and opcode are sampled combinationally; result and flags are registered on the rising clock edge (one-cycle latency).
- Serves as the datapath execute stage. A valid strobe travels with each result.

Parameters:
- WIDTH, 8, operand/result width. All values in this spec assume 8. The carry, overflow and sign bit positions follow WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  issue strobe; operands are captured and a result is produced only when high
- a  input  8  operand A
- b  input  8  operand B
- op  input  3  operation select
- z  output  8  registered result
- cout  output  1  registered carry/borrow flag
- ov  output  1  registered signed-overflow flag
- sign  output  1  registered sign flag (equals z[7])
- valid  output  1  high for one cycle after each en cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while rst is high, z=0, cout=0, ov=0, sign=0 and valid=0, regardless of clk. Release of rst takes effect at the next rising edge.
- If en=1 at a rising edge:
  - z, cout, ov and sign load the function of that cycle's a, b and op.
  - valid<=1.
- If en=0 at a rising edge: z and the flags hold their values; valid<=0.
- Latency is exactly one cycle. Back-to-back en gives one result per cycle. There is no backpressure.
- Opcodes (8-bit modular arithmetic):
  - 000 ADD: z=a+b; cout=bit 8 of the 9-bit sum; ov=(a[7]==b[7]) && (z[7]!=a[7]).
  - 001 SUB: z=a-b, computed as a+~b+1; cout=carry of that sum, so 1 means no borrow (a>=b unsigned); ov=(a[7]!=b[7]) && (z[7]!=a[7]).
  - 010 AND: z=a&b; cout=0; ov=0.
  - 011 OR: z=a|b; cout=0; ov=0.
  - 100 XOR: z=a^b; cout=0; ov=0.
  - 101 SHL: z={a[6:0],0}; cout=a[7]; ov=0. b is ignored.
  - 110 SHR (logical): z={0,a[7:1]}; cout=a[0]; ov=0. b is ignored.
  - 111 SLT (signed): z=8'd1 if $signed(a)<$signed(b), else 8'd0; cout=0; ov=0.
- sign=z[7] for every opcode.
- Boundaries:
  - ADD 255+1 gives z=0, cout=1.
  - SUB 0-1 gives z=255, cout=0.
  - SUB 128-1 gives z=127, ov=1.
  - Equal operands on SLT give 0.
- Reset asserted mid-stream discards the in-flight result; valid=0 immediately.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> all outputs 0 immediately; hold rst low with en=0 -> outputs stay 0.
- a=100, b=124, op swept 000..111 with en=1, one op per cycle. Expected results one cycle after each op:
  - ADD: z=224, cout=0, ov=1, sign=1
  - SUB: z=232, cout=0, ov=0, sign=1
  - AND: z=100
  - OR: z=124
  - XOR: z=24
  - SHL: z=200, cout=0, sign=1
  - SHR: z=50, cout=0
  - SLT: z=1
  - valid=1 each cycle.
- a=110, b=200, op swept 000..111. Expected:
  - ADD: z=54, cout=1, ov=0, sign=0
  - SUB: z=166, cout=0, ov=1, sign=1
  - AND: z=72
  - OR: z=238
  - XOR: z=166
  - SHL: z=220, cout=0
  - SHR: z=55, cout=0
  - SLT: z=0
- Edges:
  - 255+1 -> z=0, cout=1, ov=0.
  - 127+1 -> z=128, ov=1, sign=1.
  - 0-1 -> z=255, cout=0.
  - SHL of 0x81 -> z=0x02, cout=1.
  - SHR of 0x01 -> z=0, cout=1.
- Enable: drop en for 3 cycles while changing a, b and op -> z and flags hold the last result, valid=0; raise en -> new result after one edge.
- Mid-stream reset: pulse rst during back-to-back ADDs -> outputs clear at once; the first result after release appears one cycle after the next en edge.
